shift_add_multiplier_32_bit: RTL

//  - Sequential radix-2 shift-and-add multiplier: 32x32 -> 64-bit product.
//  - Sits directly upstream of binary_adder_subtractor_32_bit. Drives its a/b/cin

---
 rtl/mul_pkg.sv | 15 +
 rtl/binary_adder_subtractor_32_bit.sv | 23 ++
 rtl/shift_add_multiplier_32_bit.sv | 110 +++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared constants for the shift-and-add multiplier: controller state encoding
// and datapath geometry.
package mul_pkg;

    // Controller state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Operand width (must match the partial-product adder) and index of the
    // final iteration.
    localparam int MUL_WIDTH     = 32;
    localparam int MUL_LAST_ITER = 31;

endpackage

// File: rtl/binary_adder_subtractor_32_bit.sv
// 32-bit adder/subtractor used as the partial-product adder.
// cin = 0 : s = a + b
// cin = 1 : s = a + ~b + 1  (i.e. a - b)
// cout is the carry out of bit 31 of that sum.
module binary_adder_subtractor_32_bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s,
    output logic        cout
);

    logic [31:0] b_eff;
    logic [32:0] sum;

    // Invert b when subtracting; cin supplies the +1 of the two's complement
    assign b_eff = cin ? ~b : b;
    assign sum   = {1'b0, a} + {1'b0, b_eff} + {32'd0, cin};

    assign s    = sum[31:0];
    assign cout = sum[32];

endmodule

// File: rtl/shift_add_multiplier_32_bit.sv
// Sequential radix-2 shift-and-add multiplier, 32x32 -> 64-bit product.
// One multiplication in flight; 32 iterations, always run to completion.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only in IDLE; out_valid is high only in
// DONE, where product is held stable until out_valid & out_ready.
//
// Optional feature: define SIGNED_MODE_EN for two's-complement operands and
// product (last iteration subtracts the multiplicand). Undefined: unsigned.
module shift_add_multiplier_32_bit
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,  // only 32 is supported (adder width)
    parameter int CNT_W = 6           // 2**CNT_W must exceed WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    logic [1:0]       state;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mc_r;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] adder_a;
    logic [WIDTH-1:0] adder_b;
    logic             adder_cin;
    logic [WIDTH-1:0] adder_s;
    logic             adder_cout;
    logic             sub_step;
    logic             shin;
    logic             last_iter;

    assign last_iter = (cnt == CNT_W'(MUL_LAST_ITER));

`ifdef SIGNED_MODE_EN
    logic b_eff_msb;

    // Final iteration subtracts: the multiplier's MSB carries negative weight
    assign sub_step  = (state == ST_RUN) && last_iter;
    // Sign of the 33-bit sum a + b_eff + cin, so the shifted-in bit never overflows
    assign b_eff_msb = adder_b[WIDTH-1] ^ adder_cin;
    assign shin      = adder_a[WIDTH-1] ^ b_eff_msb ^ adder_cout;
`else
    // Unsigned: the carry is the 33rd bit of the partial sum
    assign sub_step  = 1'b0;
    assign shin      = adder_cout;
`endif

    // Adder operands come straight from the registers
    assign adder_a   = hi;
    assign adder_b   = lo[0] ? mc_r : '0;
    assign adder_cin = sub_step;

    binary_adder_subtractor_32_bit u_addsub (
        .a    (adder_a),
        .b    (adder_b),
        .cin  (adder_cin),
        .s    (adder_s),
        .cout (adder_cout)
    );

    // Controller: IDLE -> RUN (32 iterations) -> DONE -> IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) state <= ST_RUN;
                ST_RUN:  if (last_iter) state <= ST_DONE;
                ST_DONE: if (out_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Datapath: load operands on accept, then add-and-shift once per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi   <= '0;
            lo   <= '0;
            mc_r <= '0;
            cnt  <= '0;
        end else begin
            if (state == ST_IDLE && in_valid) begin
                mc_r <= mcand;
                lo   <= mplier;
                hi   <= '0;
                cnt  <= '0;
            end else if (state == ST_RUN) begin
                hi  <= {shin, adder_s[WIDTH-1:1]};
                lo  <= {adder_s[0], lo[WIDTH-1:1]};
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign product   = {hi, lo};

endmodule
